nor_event_counter: RTL
======================

// Module: nor_event_counter
// PURPOSE
//   Consumes the 1-bit output Z of a port_nor gate. Z is asynchronous to clk and
//   may be driven directly by switches or other gates.
//   Synchronises Z into the clk domain and detects its rising edges, i.e. the
//   moments when both NOR inputs become 0. Counts those events with saturation,
//   flags a programmable threshold, and offers a req/ack snapshot read of the count.
// PARAMETERS
//   CNT_W        8    width of event counter and snapshot
//   THRESH       10   count value that sets thresh_hit (must be < 2**CNT_W)
//   SYNC_STAGES  2    flip-flops in input synchroniser (>= 2)
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   z_in         in   1      NOR output Z, asynchronous
//   clr          in   1      synchronous clear of count/flags
//   rd_req       in   1      snapshot request (level, sampled each cycle)
//   snap_ack     in   1      consumer has taken snapshot
//   event_pulse  out  1      1-cycle pulse per detected rising edge of z_in
//   count        out  CNT_W  live event count
//   thresh_hit   out  1      sticky: count has reached THRESH
//   overflow     out  1      sticky: event arrived while count saturated
//   snap_valid   out  1      snapshot held and valid
//   snap_count   out  CNT_W  captured count
// BEHAVIOUR
//   - Reset (async, rst_n=0): all sync flops, the edge-prev flop, count,
//     thresh_hit, overflow, snap_valid, snap_count and event_pulse go to 0.
//     The FSM goes to SNAP_IDLE. Reset asserted mid-operation aborts any snapshot.
//   - Synchroniser: z_in passes through SYNC_STAGES flops to give z_s.
//     The edge term is rise = z_s & ~z_prev.
//     event_pulse is registered rise. It is 1 exactly SYNC_STAGES+1 rising clk
//     edges after z_in rises, when z_in is stable across setup.
//     Each pulse lasts one cycle. z_in held high produces no further pulses.
//   - Counter, in priority order:
//       clr=1: count, thresh_hit and overflow go to 0, and any event this cycle
//         is dropped. snapshot state is untouched.
//       else if event_pulse=1 and count==2**CNT_W-1: count holds and overflow is set.
//       else if event_pulse=1: count increments by 1. thresh_hit is set when the
//         new value == THRESH.
//   - thresh_hit and overflow stay 1 until clr or reset.
//   - Snapshot FSM:
//       SNAP_IDLE: rd_req=1 captures the current registered count, i.e. the value
//         before any same-cycle increment, into snap_count. Next state is
//         SNAP_HOLD, and snap_valid is 1 from the next cycle.
//       SNAP_HOLD: snap_count is frozen and snap_valid=1. snap_ack=1 returns to
//         SNAP_IDLE, with snap_valid=0 next cycle and snap_count retaining its
//         last value.
//     rd_req in SNAP_HOLD is ignored, including when it coincides with snap_ack;
//     a new request must be seen in SNAP_IDLE. snap_ack in SNAP_IDLE is ignored.
//     A clr during SNAP_HOLD does not alter snap_count.
//   - All arithmetic is unsigned, CNT_W bits, with no wrap-around (saturates).
// STRUCTURE
//   - Shared include nor_event_defs.vh holds: SNAP_IDLE=1'b0, SNAP_HOLD=1'b1,
//     default CNT_W and THRESH.
//   - One sub-module, sync_edge_det (SYNC_STAGES; clk, rst_n, d, rise), provides
//     the synchroniser and edge detector.
//   - Counter, flags and snapshot FSM live in the top-level module.
// TESTING (bench drives z_in from a port_nor instance, X1/X2 stimulus)
//   1. Reset, then X1=X2=0 held for 20 cycles
//      -> exactly one event_pulse, at cycle 3 after the Z rise; count=1.
//   2. 10 pulses of X1=X2=0, each separated by X1=1
//      -> count=10, thresh_hit=1 at the 10th pulse and not before.
//   3. CNT_W=4, 17 events
//      -> count holds at 15 from event 15 onwards; overflow=1 after event 16.
//   4. clr asserted in the same cycle as event_pulse
//      -> count=0, thresh_hit=0, overflow=0; the event is not counted.
//   5. count=5, rd_req=1 together with an event
//      -> snap_count=5 and snap_valid=1 next cycle, count=6. A further event and
//         rd_req in HOLD leave snap_count=5. snap_ack gives snap_valid=0 next cycle.
//   6. rst_n pulsed low asynchronously mid-cycle in SNAP_HOLD with count=7
//      -> all outputs 0 immediately, FSM in SNAP_IDLE; counting resumes after
//         release.

Source files
------------

// File: rtl/nor_event_counter_pkg.sv
// Shared definitions for the NOR event counter: snapshot FSM states and
// default sizing.
package nor_event_counter_pkg;

    localparam int unsigned DefCntW   = 8;
    localparam int unsigned DefThresh = 10;

    typedef enum logic {
        SnapIdle = 1'b0,
        SnapHold = 1'b1
    } snap_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector on the synchronised value.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_z_s;

    assign w_z_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= w_z_s;
        end
    end

    assign rise = w_z_s & ~r_prev;

endmodule

// File: rtl/nor_event_counter.sv
// Counts synchronised rising edges of a NOR output with saturation, sticky
// threshold/overflow flags and a req/ack snapshot of the count.
module nor_event_counter
    import nor_event_counter_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned THRESH      = DefThresh,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             clr,
    input  logic             rd_req,
    input  logic             snap_ack,
    output logic             event_pulse,
    output logic [CNT_W-1:0] count,
    output logic             thresh_hit,
    output logic             overflow,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_count
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] ThreshV = CNT_W'(THRESH);

    logic             w_rise;
    logic             r_event_pulse;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_thresh_hit;
    logic             r_overflow;
    snap_state_e      r_state;
    snap_state_e      w_state_d;
    logic [CNT_W-1:0] r_snap_count;
    logic [CNT_W-1:0] w_snap_count_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (z_in),
        .rise  (w_rise)
    );

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_event_pulse <= 1'b0;
            r_count       <= '0;
            r_thresh_hit  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_event_pulse <= w_rise;
            // clr wins over a coincident event, which is then lost.
            if (clr) begin
                r_count      <= '0;
                r_thresh_hit <= 1'b0;
                r_overflow   <= 1'b0;
            end else if (r_event_pulse && (r_count == CntMax)) begin
                r_overflow <= 1'b1;
            end else if (r_event_pulse) begin
                r_count <= w_count_inc;
                if (w_count_inc == ThreshV) begin
                    r_thresh_hit <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SnapIdle;
            r_snap_count <= '0;
        end else begin
            r_state      <= w_state_d;
            r_snap_count <= w_snap_count_d;
        end
    end

    // Capture uses the registered count, so a same-cycle increment is not seen.
    always_comb begin
        w_state_d      = r_state;
        w_snap_count_d = r_snap_count;
        unique case (r_state)
            SnapIdle: begin
                if (rd_req) begin
                    w_state_d      = SnapHold;
                    w_snap_count_d = r_count;
                end
            end
            SnapHold: begin
                if (snap_ack) begin
                    w_state_d = SnapIdle;
                end
            end
            default: w_state_d = SnapIdle;
        endcase
    end

    assign event_pulse = r_event_pulse;
    assign count       = r_count;
    assign thresh_hit  = r_thresh_hit;
    assign overflow    = r_overflow;
    assign snap_valid  = (r_state == SnapHold);
    assign snap_count  = r_snap_count;

endmodule
